pool_out_packer: RTL and testbench
==================================

// Module: pool_out_packer
// PURPOSE
//  Downstream of the conv/activation/pool pipeline: captures each pooled N-bit sample (data_out/valid_op/end_op).
//  Packs L samples into one N*L-bit word, lane 0 in the LSBs.
//  Buffers words in a DEPTH-entry FIFO toward the memory writer, with a valid/ready handshake and per-frame last marking.
//  The upstream pipeline cannot be stalled, so the block reports loss instead of applying backpressure.
// PARAMETERS
//  N        8   sample width, (N,Q) fixed point, passed through untouched
//  L        4   samples packed per output word
//  DEPTH    8   FIFO depth in words, power of 2, >=2
//  OUT_CNT  16  pooled samples per frame, ((MAP_SIZE-k+1)/p)**2
// PORTS
//  clk           in   1               rising-edge clock
//  global_rst_n  in   1               async active-low reset
//  clr           in   1               sync clear: drops lanes, counters, FIFO contents and flags
//  valid_in      in   1               data_in is valid this cycle (pooler valid_op)
//  end_in        in   1               upstream end-of-map (pooler end_op)
//  data_in       in   N               pooled sample
//  m_data        out  N*L             FIFO head word
//  m_valid       out  1               FIFO non-empty
//  m_ready       in   1               consumer accepts head word when m_valid&&m_ready
//  m_last        out  1               head word is the final word of its frame
//  frame_done    out  1               1-cycle pulse when a frame's last word is pushed
//  overflow      out  1               sticky: a word was dropped because the FIFO was full
//  level         out  $clog2(DEPTH)+1 FIFO occupancy
// BEHAVIOUR
//  Reset and clr
//   - All outputs 0; lane_cnt=0, samp_cnt=0, FIFO empty, FSM=ACCUM.
//   - clr takes priority over every other event in its cycle.
//  Capture
//   - valid_in: data_in goes into lane lane_cnt; lane_cnt++ and samp_cnt++.
//   - When lane L-1 fills, the word is pushed at that same edge; m_valid is high the next cycle.
//   - Latency from the last lane's valid_in to m_valid is 1 clk.
//  Frame termination, on whichever comes first:
//   - samp_cnt reaches OUT_CNT.
//   - end_in with samp_cnt>0.
//  At termination:
//   - Any partial word is pushed with its unused lanes = 0.
//   - The pushed word has last=1.
//   - frame_done pulses on the same edge as that push.
//   - lane_cnt and samp_cnt return to 0.
//  Other termination rules
//   - valid_in and end_in in the same cycle: the sample is captured first, then the frame terminates with it included.
//   - end_in with samp_cnt==0 (already terminated on count): ignored, no empty word is pushed.
//  FSM
//   - ACCUM -> FLUSH when a partial word must be pushed and the FIFO is full.
//     FLUSH retries the push every cycle.
//     It does not accept valid_in: such samples are dropped and overflow is set.
//   - FLUSH -> ACCUM once the push succeeds.
//   - In the normal case the push succeeds at once and the FSM never leaves ACCUM.
//  FIFO
//   - Push is allowed when not full, or when full and a pop occurs in the same cycle (simultaneous push/pop at full is legal, level unchanged).
//   - A full word arriving with no free slot is dropped and overflow is set.
//     lane_cnt and samp_cnt still advance, so frame alignment is preserved.
//   - Pop on an empty FIFO: no effect.
//   - Pointers wrap modulo DEPTH.
//   - m_data and m_last hold stable while m_valid && !m_ready.
//  Widths
//   - No arithmetic on data; samples are copied bit-exact.
//   - samp_cnt is $clog2(OUT_CNT+1) bits.
// CONFIGURATION
//  FRAME_CHECK_EN defined:
//   - Adds output frame_err (1b, sticky, cleared by reset/clr).
//   - Set when end_in arrives with 0<samp_cnt<OUT_CNT (short frame).
//   - Set when end_in has not arrived by the time OUT_CNT was reached and valid_in keeps coming; the first sample past OUT_CNT sets it and starts a new frame.
//  FRAME_CHECK_EN undefined:
//   - No frame_err port and no check logic; termination behaviour is identical.
// STRUCTURE
//  - Shared package accel_pkg: N, Q defaults; OUT_CNT derivation from MAP_SIZE/k/p; clog2-based pointer/count widths; FSM state encoding (ACCUM, FLUSH).
//  - One sub-module: out_fifo, a synchronous FIFO, width N*L+1 (data+last), DEPTH entries, with full/empty/level outputs.
//  - Packing shift register, counters and FSM are in this module.
// TESTING
//  - Reset: global_rst_n=0 mid-frame with 2 lanes held -> next cycle m_valid=0, level=0, overflow=0; the next 4 samples form a clean word.
//  - Stream 16 samples 0x01..0x10, m_ready=1:
//    - 4 words, first 0x04030201, last 0x100F0E0D with m_last=1.
//    - frame_done is a single pulse, 1 clk before the last word's m_valid.
//  - 6 samples 0xA1..0xA6 then end_in:
//    - second word 0x0000A6A5 with m_last=1.
//    - FRAME_CHECK_EN: frame_err=1.
//  - m_ready=0 for 40 samples (10 words, DEPTH=8):
//    - level saturates at 8, overflow=1.
//    - m_data stays 0x04030201 (samples 0x01..0x04) until released; after the drain, 8 words have been seen.
//  - FIFO full with m_ready=1 on the cycle a 4th lane arrives -> push and pop both succeed, level stays 8, overflow=0.
//  - valid_in and end_in in the same cycle as sample #3 -> word 0x00030201 with m_last=1, frame_done pulses.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared definitions for the conv/activation/pool accelerator datapath.
//   - default sample format (N,Q) and packing geometry
//   - derivation of the pooled-sample count per frame from MAP_SIZE/k/p
//   - state encoding of the output packer FSM
package accel_pkg;

    localparam int N_DEF        = 8;   // sample width
    localparam int Q_DEF        = 4;   // fractional bits (data is never interpreted here)
    localparam int L_DEF        = 4;   // samples per packed word
    localparam int DEPTH_DEF    = 8;   // output FIFO depth in words
    localparam int MAP_SIZE_DEF = 10;  // input feature map edge
    localparam int K_DEF        = 3;   // conv kernel edge
    localparam int P_DEF        = 2;   // pooling window edge

    // Pooled samples per frame: ((MAP_SIZE-k+1)/p)**2
    function automatic int out_cnt_f(input int map_size, input int k, input int p);
        int edge_len;
        edge_len = (map_size - k + 1) / p;
        return edge_len * edge_len;
    endfunction

    localparam int OUT_CNT_DEF = out_cnt_f(MAP_SIZE_DEF, K_DEF, P_DEF);

    // Width of a counter that must hold 0..n inclusive
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic [0:0] {
        ACCUM = 1'b0,  // collecting samples, pushes succeed immediately
        FLUSH = 1'b1   // a terminating partial word waits for a free FIFO slot
    } pack_state_t;

endpackage

// File: rtl/pool_out_packer_if.sv
// Packed-word stream from the pool output packer toward the memory writer.
//   m_data  : packed word, lane 0 in the LSBs
//   m_valid : word available
//   m_ready : consumer accepts the word when m_valid && m_ready
//   m_last  : word is the final word of its frame
interface pool_out_packer_if #(
    parameter int W = 32
) ();
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/out_fifo.sv
// Synchronous show-ahead FIFO used by pool_out_packer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over push/pop
//   push, din  : write request and data (ignored when full unless a pop frees the slot)
//   pop, dout  : read request and head word (dout is 0 while empty)
//   full, empty, level : occupancy status
module out_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign level = count_q;
    // Head is read combinationally so the consumer sees it the cycle after the push.
    assign dout  = empty ? '0 : mem[rd_ptr_q];

    // A push at full is legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);   // DEPTH is a power of 2: wraps naturally
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/pool_out_packer.sv
// pool_out_packer: packs L pooled N-bit samples into N*L-bit words (lane 0 in the LSBs),
// marks the final word of each frame and buffers words in a DEPTH-entry FIFO.
// The upstream pooler cannot be stalled, so loss is reported through the sticky
// overflow flag instead of backpressure.
// Optional feature macro: FRAME_CHECK_EN adds the sticky frame_err output.
// Ports:
//   clk, global_rst_n : clock, asynchronous active-low reset
//   clr               : synchronous clear of lanes, counters, FIFO and flags
//   valid_in, end_in, data_in : pooler sample stream (valid_op / end_op / data_out)
//   m (master)        : packed-word stream m_data/m_valid/m_ready/m_last
//   frame_done        : high in the cycle whose edge pushes a frame's last word
//   overflow          : sticky, a word or sample was dropped
//   level             : FIFO occupancy
//   frame_err         : (FRAME_CHECK_EN) sticky short/over-long frame indication
module pool_out_packer
    import accel_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int L       = L_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int OUT_CNT = OUT_CNT_DEF
) (
    input  logic                   clk,
    input  logic                   global_rst_n,
    input  logic                   clr,
    input  logic                   valid_in,
    input  logic                   end_in,
    input  logic [N-1:0]           data_in,
    pool_out_packer_if.master      m,
    output logic                   frame_done,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
`ifdef FRAME_CHECK_EN
    ,
    output logic                   frame_err
`endif
);
    localparam int W  = N * L;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam int SW = cnt_w(OUT_CNT);

    pack_state_t   state_q, state_d;
    logic [W-1:0]  lanes_q, lanes_d;
    logic [LW-1:0] lane_cnt_q, lane_cnt_d;
    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic          overflow_q, overflow_d;

    logic          take, lane_full, at_count, term, can_push, pop;
    logic [SW-1:0] samp_cap;
    logic [W-1:0]  word_cap, push_word;
    logic          push, push_last;
    logic          fifo_full, fifo_empty;
    logic [W:0]    fifo_dout;

    // Samples offered while a flush is pending are lost, not captured.
    assign take      = valid_in && (state_q == ACCUM);
    assign samp_cap  = samp_cnt_q + SW'(take);
    assign lane_full = take && (lane_cnt_q == LW'(L - 1));
    assign at_count  = take && (samp_cap == SW'(OUT_CNT));
    // end_in after a count-terminated frame sees samp_cap==0 and is ignored.
    assign term      = at_count || (end_in && (samp_cap != '0));
    assign pop       = m.m_valid && m.m_ready;
    assign can_push  = !fifo_full || pop;

    // Lanes above the write position are always zero because lanes are cleared
    // after every push, so a partial word needs no extra masking.
    always_comb begin
        word_cap = lanes_q;
        if (take) word_cap[lane_cnt_q * N +: N] = data_in;
    end

    always_comb begin
        state_d    = state_q;
        lanes_d    = lanes_q;
        lane_cnt_d = lane_cnt_q;
        samp_cnt_d = samp_cnt_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        push_word  = word_cap;
        push_last  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ACCUM: begin
                lanes_d    = word_cap;
                samp_cnt_d = samp_cap;
                if (take) lane_cnt_d = lane_cnt_q + LW'(1);
                if (lane_full || term) begin
                    lanes_d    = '0;
                    lane_cnt_d = '0;
                    if (term) samp_cnt_d = '0;
                    push_last = term;
                    if (can_push) begin
                        push       = 1'b1;
                        frame_done = term;
                    end else if (term && !lane_full) begin
                        // Keep the partial last word and retry; counters already restart.
                        lanes_d = word_cap;
                        state_d = FLUSH;
                    end else begin
                        // Full word lost; counters still advance to keep frame alignment.
                        overflow_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                push_word = lanes_q;
                push_last = 1'b1;
                if (valid_in) overflow_d = 1'b1;
                if (can_push) begin
                    push       = 1'b1;
                    frame_done = 1'b1;
                    lanes_d    = '0;
                    state_d    = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q    <= ACCUM;
            lanes_q    <= '0;
            lane_cnt_q <= '0;
            samp_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            state_q    <= ACCUM;
            lanes_q    <= '0;
            lane_cnt_q <= '0;
            samp_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lanes_q    <= lanes_d;
            lane_cnt_q <= lane_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef FRAME_CHECK_EN
    logic frame_err_q, frame_err_d;
    logic await_end_q, await_end_d;   // frame hit OUT_CNT without end_in

    always_comb begin
        frame_err_d = frame_err_q;
        await_end_d = await_end_q;
        if (take && await_end_q) begin
            // First sample past OUT_CNT: flag it, it opens the next frame.
            frame_err_d = 1'b1;
            await_end_d = 1'b0;
        end
        if (end_in) begin
            await_end_d = 1'b0;
            if ((samp_cap != '0) && (samp_cap != SW'(OUT_CNT))) frame_err_d = 1'b1;
        end
        if (at_count && !end_in) await_end_d = 1'b1;
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            frame_err_q <= 1'b0;
            await_end_q <= 1'b0;
        end else if (clr) begin
            frame_err_q <= 1'b0;
            await_end_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            await_end_q <= await_end_d;
        end
    end

    assign frame_err = frame_err_q;
`endif

    out_fifo #(
        .W     (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (global_rst_n),
        .clr   (clr),
        .push  (push),
        .din   ({push_last, push_word}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign m.m_data  = fifo_dout[W-1:0];
    assign m.m_last  = fifo_dout[W];
    assign m.m_valid = !fifo_empty;
endmodule

// File: tb/tb_pool_out_packer.sv
module tb_pool_out_packer;
    logic       clk = 1'b0;
    logic       global_rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       valid_in = 1'b0;
    logic       end_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       frame_done;
    logic       overflow;
    logic [3:0] level;
`ifdef FRAME_CHECK_EN
    logic       frame_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [32:0] popped[$];

    pool_out_packer_if #(.W(32)) bus ();

    always #5 clk = ~clk;

    pool_out_packer dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .clr          (clr),
        .valid_in     (valid_in),
        .end_in       (end_in),
        .data_in      (data_in),
        .m            (bus),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .level        (level)
`ifdef FRAME_CHECK_EN
        ,
        .frame_err    (frame_err)
`endif
    );

    // Record every accepted word as {last, data}
    always @(posedge clk) begin
        if (global_rst_n && !clr && bus.m_valid && bus.m_ready)
            popped.push_back({bus.m_last, bus.m_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        valid_in = 1'b1;
        end_in   = e;
        data_in  = d;
        tick();
        valid_in = 1'b0;
        end_in   = 1'b0;
        data_in  = 8'h00;
    endtask

    task automatic do_clr();
        bus.m_ready = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        popped.delete();
    endtask

    task automatic test_reset();
        bus.m_ready = 1'b0;
        tick();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %0b exp 0", bus.m_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rst_flags got ovf=%0b fd=%0b exp 0/0", overflow, frame_done); end
        global_rst_n = 1'b1;
        tick();
        send(8'hEE, 1'b0);
        send(8'hEF, 1'b0);
        global_rst_n = 1'b0;
        tick();
        checks++; if (bus.m_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst got v=%0b lvl=%0d ovf=%0b exp 0/0/0", bus.m_valid, level, overflow); end
        global_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b0);
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h14131211 || bus.m_last !== 1'b0 || level !== 4'd1) begin
            errors++; $display("FAIL post_rst_word got v=%0b d=%08h l=%0b lvl=%0d exp 1/14131211/0/1", bus.m_valid, bus.m_data, bus.m_last, level); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        int fd_cnt;
        do_clr();
        bus.m_ready = 1'b1;
        fd_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(i);
            #1;
            if (frame_done === 1'b1) fd_cnt++;
            if (i == 16) begin
                checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL stream_fd_at16 got %0b exp 1", frame_done); end
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        data_in  = 8'h00;
        #1;
        if (frame_done === 1'b1) fd_cnt++;
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h100F0E0D || bus.m_last !== 1'b1) begin
            errors++; $display("FAIL stream_last_head got v=%0b d=%08h l=%0b exp 1/100f0e0d/1", bus.m_valid, bus.m_data, bus.m_last); end
        tick();
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL stream_fd_pulses got %0d exp 1", fd_cnt); end
        checks++; if (popped.size() !== 4) begin errors++; $display("FAIL stream_words got %0d exp 4", popped.size()); end
        checks++; if (popped[0] !== {1'b0, 32'h04030201}) begin errors++; $display("FAIL stream_word0 got %09h exp 004030201", popped[0]); end
        checks++; if (popped[3] !== {1'b1, 32'h100F0E0D}) begin errors++; $display("FAIL stream_word3 got %09h exp 1100f0e0d", popped[3]); end
`ifdef FRAME_CHECK_EN
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL stream_frame_err got %0b exp 0", frame_err); end
`endif
        $display("test_stream done, %0d words", popped.size());
    endtask

    task automatic test_end_short();
        do_clr();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(8'hA1 + 8'(i), 1'b0);
        end_in = 1'b1;
        #1;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL short_fd got %0b exp 1", frame_done); end
        @(posedge clk); #1;
        end_in = 1'b0;
        tick();
        checks++; if (popped[0] !== {1'b0, 32'hA4A3A2A1}) begin errors++; $display("FAIL short_word0 got %09h exp 0a4a3a2a1", popped[0]); end
        checks++; if (popped[1] !== {1'b1, 32'h0000A6A5}) begin errors++; $display("FAIL short_word1 got %09h exp 10000a6a5", popped[1]); end
`ifdef FRAME_CHECK_EN
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_frame_err got %0b exp 1", frame_err); end
        do_clr();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL clr_frame_err got %0b exp 0", frame_err); end
`endif
        $display("test_end_short done");
    endtask

    task automatic test_overflow();
        do_clr();
        for (int i = 1; i <= 40; i++) send(8'(i), 1'b0);
        checks++; if (level !== 4'd8 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_state got lvl=%0d ovf=%0b exp 8/1", level, overflow); end
        checks++; if (bus.m_data !== 32'h04030201 || bus.m_last !== 1'b0) begin errors++; $display("FAIL ovf_head got %08h l=%0b exp 04030201/0", bus.m_data, bus.m_last); end
        tick();
        checks++; if (bus.m_data !== 32'h04030201) begin errors++; $display("FAIL ovf_hold got %08h exp 04030201", bus.m_data); end
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (popped.size() !== 8 || level !== 4'd0) begin errors++; $display("FAIL ovf_drain got words=%0d lvl=%0d exp 8/0", popped.size(), level); end
        checks++; if (popped[3] !== {1'b1, 32'h100F0E0D}) begin errors++; $display("FAIL ovf_word3 got %09h exp 1100f0e0d", popped[3]); end
        checks++; if (popped[7] !== {1'b1, 32'h201F1E1D}) begin errors++; $display("FAIL ovf_word7 got %09h exp 1201f1e1d", popped[7]); end
        $display("test_overflow done, %0d words", popped.size());
    endtask

    task automatic test_full_pushpop();
        do_clr();
        for (int i = 1; i <= 35; i++) send(8'(i), 1'b0);
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL pp_prefill got lvl=%0d exp 8", level); end
        bus.m_ready = 1'b1;
        send(8'd36, 1'b0);
        bus.m_ready = 1'b0;
        checks++; if (level !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL pp_level got lvl=%0d ovf=%0b exp 8/0", level, overflow); end
        checks++; if (bus.m_data !== 32'h08070605) begin errors++; $display("FAIL pp_head got %08h exp 08070605", bus.m_data); end
        bus.m_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        checks++; if (popped.size() !== 9) begin errors++; $display("FAIL pp_words got %0d exp 9", popped.size()); end
        checks++; if (popped[8] !== {1'b0, 32'h24232221}) begin errors++; $display("FAIL pp_word8 got %09h exp 024232221", popped[8]); end
        $display("test_full_pushpop done");
    endtask

    task automatic test_same_cycle_end();
        do_clr();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        valid_in = 1'b1; end_in = 1'b1; data_in = 8'h03;
        #1;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL sc_fd got %0b exp 1", frame_done); end
        @(posedge clk); #1;
        valid_in = 1'b0; end_in = 1'b0; data_in = 8'h00;
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h00030201 || bus.m_last !== 1'b1 || level !== 4'd1) begin
            errors++; $display("FAIL sc_word got v=%0b d=%08h l=%0b lvl=%0d exp 1/00030201/1/1", bus.m_valid, bus.m_data, bus.m_last, level); end
`ifdef FRAME_CHECK_EN
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL sc_frame_err got %0b exp 1", frame_err); end
`endif
        end_in = 1'b1;
        #1;
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL stray_end_fd got %0b exp 0", frame_done); end
        @(posedge clk); #1;
        end_in = 1'b0;
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL stray_end_level got %0d exp 1", level); end
        $display("test_same_cycle_end done");
    endtask

    task automatic test_flush();
        do_clr();
        for (int i = 1; i <= 32; i++) send(8'(i), 1'b0);
        send(8'h21, 1'b0);
        send(8'h22, 1'b1);          // partial last word, FIFO full -> wait
        checks++; if (overflow !== 1'b0 || level !== 4'd8) begin errors++; $display("FAIL fl_wait got ovf=%0b lvl=%0d exp 0/8", overflow, level); end
        send(8'h55, 1'b0);          // offered during the flush: lost
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fl_drop got ovf=%0b exp 1", overflow); end
        bus.m_ready = 1'b1;
        #1;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL fl_fd got %0b exp 1", frame_done); end
        for (int i = 0; i < 10; i++) tick();
        checks++; if (popped.size() !== 9) begin errors++; $display("FAIL fl_words got %0d exp 9", popped.size()); end
        checks++; if (popped[8] !== {1'b1, 32'h00002221}) begin errors++; $display("FAIL fl_word8 got %09h exp 100002221", popped[8]); end
        $display("test_flush done");
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_stream();
        test_end_short();
        test_overflow();
        test_full_pushpop();
        test_same_cycle_end();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
